rv32_pipe_reg: RTL
==================

Name: rv32_pipe_reg

Overview:
- Parametrised elastic pipeline register for the RV32I datapath; successor to the single-bit flip-flop.
- Carries a WIDTH-bit payload through STAGES registered stages with valid/ready handshake, stall (backpressure), flush and occupancy count.
- Used between core pipeline phases (IF/ID, ID/EX, ...) and as a general retiming element.

Parameters:
- WIDTH, 32, payload width in bits (>=1)
- STAGES, 1, number of register stages (>=1)
- RESET_VAL, 0, payload value loaded into every stage on reset (WIDTH bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- flush  in  1  synchronous clear of all stage valid bits
- in_valid  in  1  upstream payload valid
- in_ready  out  1  block accepts payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  payload at last stage valid
- out_ready  in  1  downstream accepts payload
- out_data  out  WIDTH  payload of last stage
- occupancy  out  $clog2(STAGES+2)  number of valid entries held

Behaviour:
- Reset (rst_n=0 at posedge): all stage valids=0, all stage data=RESET_VAL, occupancy=0, skid entry (if present) empty. Outputs after reset: out_valid=0, out_data=RESET_VAL, in_ready=1. Reset has priority over flush and handshakes and aborts any in-flight transfer.
- Stage k (0=input side, STAGES-1=output) loads from stage k-1 (stage 0 from input) when it is empty or its contents move on this cycle. Last stage moves when out_valid && out_ready.
- Handshake: transfer occurs at posedge where valid && ready are both 1. out_valid, once asserted, holds and out_data stays stable until accepted. in_ready does not depend on in_valid.
- in_ready (no skid) = !valid[0] || stage 0 moving. This is combinational through the ready chain from out_ready.
- Latency: a payload accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles after in_valid, when no stall occurs. Throughput is 1 payload/cycle with out_ready held 1.
- Bubbles collapse: an empty stage accepts from upstream even when downstream stalls.
- Data regs of an empty stage are don't-care but must not change out_data while out_valid=1.
- Flush (rst_n=1, flush=1): all valids clear at the next edge. A payload presented in the same cycle is dropped, and an out transfer in the flush cycle still counts as accepted downstream. occupancy=0 after the edge. Data regs are not reset.
- occupancy = count of valid stages (+ skid entry). It increments on accept and decrements on output transfer, with no change when both occur. Maximum is STAGES (STAGES+1 with skid); no wrap is possible.
- Full: all stages valid and out_ready=0 gives in_ready=0, and contents hold indefinitely.

Optional Feature:
- Macro PIPE_REG_SKID_EN.
- Defined: a one-entry skid buffer sits at the input and in_ready is driven directly from a register (= !skid_valid), with no combinational path from out_ready.
  - When stage 0 cannot advance and in_valid && in_ready, the payload goes to the skid.
  - The skid drains into stage 0 first, in order, before new input.
  - Capacity is STAGES+1.
  - No-stall latency is unchanged.
  - Flush and reset also empty the skid.
- Undefined: no skid, combinational in_ready, capacity STAGES.

Test Plan:
- WIDTH=32, STAGES=3; reset held 2 cycles, then released -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Stream 0x00000001..0x00000008 on consecutive cycles with out_ready=1 -> first out_valid 3 cycles after first accept, values in order, one per cycle, with no gaps.
- Send 0xDEADBEEF, 0xCAFEF00D, 0x12345678, 0x0BADF00D with out_ready=0 -> in_ready drops after 3 accepts (4 with PIPE_REG_SKID_EN), occupancy=3 (4), out_data=0xDEADBEEF stable. Then raise out_ready -> all drain in order.
- Fill 2 entries, assert flush for 1 cycle while in_valid=1 with 0xAAAAAAAA -> next cycle occupancy=0, out_valid=0, and 0xAAAAAAAA never appears on the output.
- Fill 3 entries, assert rst_n=0 mid-stream for 1 cycle -> next edge all valids 0, out_data=RESET_VAL (test with RESET_VAL=0x00000013 NOP), occupancy=0.
- Random in_valid/out_ready (50%) for 1000 cycles -> scoreboard shows in-order, lossless, duplicate-free delivery, and occupancy matches model every cycle.

Source files
------------

// File: rtl/rv32_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pipe_reg
// Purpose  : Elastic pipeline register for the RV32I datapath. It moves a
//            WIDTH-bit payload through STAGES register stages using a
//            valid/ready handshake. Empty stages (bubbles) collapse, flush
//            drops in-flight payloads, and the block reports its occupancy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      payload width in bits (>=1)
//   STAGES     number of register stages (>=1)
//   RESET_VAL  payload value loaded into every stage on reset
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous clear of all valid state
//   in_valid   in   upstream payload valid
//   in_ready   out  block accepts payload this cycle
//   in_data    in   upstream payload
//   out_valid  out  payload at last stage valid
//   out_ready  in   downstream accepts payload
//   out_data   out  payload of last stage
//   occupancy  out  number of valid entries held
// Optional feature
//   PIPE_REG_SKID_EN : adds a one-entry input skid buffer. in_ready then comes
//                      straight from a register, and capacity becomes STAGES+1.
// ============================================================================
module rv32_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES+2);

  logic [STAGES-1:0] stage_valid;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] load_ok;     // stage k may take new contents this cycle
  logic              src_valid;   // what is offered to stage 0
  logic [WIDTH-1:0]  src_data;
  logic              accept;
  logic              deliver;

  // Ready chain from the output back to stage 0. A stage can load when it
  // is empty or when every stage downstream of it can advance, which is what
  // lets bubbles collapse while the output is stalled.
  always_comb begin
    logic chain;
    chain   = out_ready;
    load_ok = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      chain      = !stage_valid[k] || chain;
      load_ok[k] = chain;
    end
  end

`ifdef PIPE_REG_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // The skid entry is older than anything on the input, so it feeds stage 0
  // first. in_ready is low whenever the skid is occupied, which means no new
  // input competes with it.
  assign in_ready  = !skid_valid;
  assign src_valid = skid_valid || in_valid;
  assign src_data  = skid_valid ? skid_data : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (load_ok[0]) begin
        skid_valid <= 1'b0;
      end
    end else if (in_valid && !load_ok[0]) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready  = load_ok[0];
  assign src_valid = in_valid;
  assign src_data  = in_data;
`endif

  assign accept    = in_valid && in_ready;
  assign deliver   = stage_valid[STAGES-1] && out_ready;
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];

  // A data register is written only when a valid payload arrives. Empty
  // stages therefore keep their old contents, and the output data cannot
  // move while it is being held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= RESET_VAL;
      end
      occupancy <= '0;
    end else if (flush) begin
      stage_valid <= '0;
      occupancy   <= '0;
    end else begin
      if (load_ok[0]) begin
        stage_valid[0] <= src_valid;
        if (src_valid) begin
          stage_data[0] <= src_data;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load_ok[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= stage_data[k-1];
          end
        end
      end
      if (accept && !deliver) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (!accept && deliver) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
